// File: rtl/uart_rx_frame_ctrl_if.sv
// UART RX frame controller bus: line, configuration and parity-checker
// inputs toward the controller, frame results back to the consumer.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
);
    logic                   RX_IN;
    logic [PRESCALE_W-1:0]  PRESCALE;
    logic                   PAR_EN;
    logic                   par_err;
    logic                   sampled_bit;
    logic                   par_chk_en;
    logic [DATA_LENGTH-1:0] P_DATA;
    logic                   data_valid;
    logic                   par_fail;
    logic                   stp_err;
    logic                   strt_err;
    logic                   busy;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, par_err,
        input  sampled_bit, par_chk_en, P_DATA, data_valid,
               par_fail, stp_err, strt_err, busy
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, par_err,
        output sampled_bit, par_chk_en, P_DATA, data_valid,
               par_fail, stp_err, strt_err, busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Oversamples the line at P clocks per bit,
// majority-votes three mid-bit samples, shifts data in LSB first, strobes
// the external parity checker, checks the stop bit and flags each frame.
module uart_rx_frame_ctrl #(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
) (
    input  logic                CLK_fsm,
    input  logic                RST_fsm,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int BCW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [BCW-1:0] C_LAST_BIT = BCW'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 r_state;
    logic [PRESCALE_W-1:0]  r_edge_cnt;
    logic [PRESCALE_W-1:0]  r_p;
    logic [BCW-1:0]         r_bit_cnt;
    logic                   r_par_en;
    logic                   r_par_flag;
    logic                   r_cap_a;
    logic                   r_cap_b;
    logic                   r_sampled_bit;
    logic                   r_par_chk_en;
    logic                   r_data_valid;
    logic                   r_par_fail;
    logic                   r_stp_err;
    logic                   r_strt_err;
    logic [DATA_LENGTH-1:0] r_p_data;

    logic [PRESCALE_W-1:0]  w_sel_p;
    logic [PRESCALE_W-1:0]  w_half;
    logic [PRESCALE_W-1:0]  w_h_m1;
    logic [PRESCALE_W-1:0]  w_h_p1;
    logic [PRESCALE_W-1:0]  w_h_p2;
    logic [PRESCALE_W-1:0]  w_h_p3;
    logic                   w_last_edge;
    logic                   w_majority;

    // Unsupported ratios fall back to 8 so a bad setting still yields a usable bit period.
    assign w_sel_p = ((bus.PRESCALE == PRESCALE_W'(16)) || (bus.PRESCALE == PRESCALE_W'(32)))
                     ? bus.PRESCALE : PRESCALE_W'(8);

    assign w_half      = r_p >> 1;
    assign w_h_m1      = w_half - PRESCALE_W'(1);
    assign w_h_p1      = w_half + PRESCALE_W'(1);
    assign w_h_p2      = w_half + PRESCALE_W'(2);
    assign w_h_p3      = w_half + PRESCALE_W'(3);
    assign w_last_edge = (r_edge_cnt == (r_p - PRESCALE_W'(1)));
    assign w_majority  = (r_cap_a & r_cap_b) | (r_cap_a & bus.RX_IN) | (r_cap_b & bus.RX_IN);

    assign bus.sampled_bit = r_sampled_bit;
    assign bus.par_chk_en  = r_par_chk_en;
    assign bus.P_DATA      = r_p_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.par_fail    = r_par_fail;
    assign bus.stp_err     = r_stp_err;
    assign bus.strt_err    = r_strt_err;
    assign bus.busy        = (r_state != IDLE);

    // Capture the line at H-1 and H, then vote with the live H+1 sample.
    always_ff @(posedge CLK_fsm or posedge RST_fsm) begin
        if (RST_fsm) begin
            r_cap_a       <= 1'b0;
            r_cap_b       <= 1'b0;
            r_sampled_bit <= 1'b0;
        end else if (r_state != IDLE) begin
            if (r_edge_cnt == w_h_m1) r_cap_a <= bus.RX_IN;
            if (r_edge_cnt == w_half) r_cap_b <= bus.RX_IN;
            if (r_edge_cnt == w_h_p1) r_sampled_bit <= w_majority;
        end
    end

    // Frame sequencer: bit timing, data assembly, parity strobe and result pulses.
    always_ff @(posedge CLK_fsm or posedge RST_fsm) begin
        if (RST_fsm) begin
            r_state      <= IDLE;
            r_edge_cnt   <= '0;
            r_p          <= '0;
            r_bit_cnt    <= '0;
            r_par_en     <= 1'b0;
            r_par_flag   <= 1'b0;
            r_par_chk_en <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_fail   <= 1'b0;
            r_stp_err    <= 1'b0;
            r_strt_err   <= 1'b0;
            r_p_data     <= '0;
        end else begin
            r_par_chk_en <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_fail   <= 1'b0;
            r_stp_err    <= 1'b0;
            r_strt_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_edge_cnt <= '0;
                    if (!bus.RX_IN) begin
                        r_state  <= START;
                        r_p      <= w_sel_p;
                        r_par_en <= bus.PAR_EN;
                    end
                end
                START: begin
                    if (w_last_edge) begin
                        r_edge_cnt <= '0;
                        if (r_sampled_bit) begin
                            r_strt_err <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_bit_cnt <= '0;
                            r_state   <= DATA;
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                    end
                end
                DATA: begin
                    if (r_edge_cnt == w_h_p2) r_p_data[r_bit_cnt] <= r_sampled_bit;
                    if (w_last_edge) begin
                        r_edge_cnt <= '0;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                    end
                end
                PARITY: begin
                    if (r_edge_cnt == w_h_p1) r_par_chk_en <= 1'b1;
                    if (r_edge_cnt == w_h_p3) r_par_flag <= r_par_flag | bus.par_err;
                    if (w_last_edge) begin
                        r_edge_cnt <= '0;
                        r_state    <= STOP;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                    end
                end
                STOP: begin
                    if (r_edge_cnt == w_h_p2) begin
                        r_stp_err    <= ~r_sampled_bit;
                        r_par_fail   <= r_par_flag;
                        r_data_valid <= r_sampled_bit & ~r_par_flag;
                        r_par_flag   <= 1'b0;
                        r_edge_cnt   <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                    end
                end
                default: begin
                    r_edge_cnt <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame controller for the UART RX path. It oversamples RX_IN at PRESCALE clocks per bit, majority-votes three mid-bit samples into sampled_bit, and deserializes data LSB-first into P_DATA. It pulses par_chk_en during the parity bit for the downstream parity checker, consumes that checker's registered par_err, checks the stop bit, and flags each frame as valid or errored.

Parameters:
DATA_LENGTH, 8, data bits per frame; P_DATA width.
PRESCALE_W, 6, width of PRESCALE input and edge counter.

Ports:
CLK_fsm  input  1  system clock, rising edge.
RST_fsm  input  1  asynchronous, active-high reset.
RX_IN  input  1  serial line, idle high; arrives already synchronized to CLK_fsm.
PRESCALE  input  PRESCALE_W  oversampling ratio: 8, 16 or 32.
PAR_EN  input  1  1 = frame carries a parity bit.
par_err  input  1  registered parity-error result from the parity checker.
sampled_bit  output  1  majority-voted bit value, feeds the parity checker.
par_chk_en  output  1  one-cycle parity-compare enable.
P_DATA  output  DATA_LENGTH  deserialized data, bit 0 received first.
data_valid  output  1  one-cycle pulse: frame received with no errors.
par_fail  output  1  one-cycle pulse: frame ended, parity error recorded.
stp_err  output  1  one-cycle pulse: stop bit sampled low.
strt_err  output  1  one-cycle pulse: start bit rejected as a glitch.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state goes to IDLE; all counters and outputs go to 0, including P_DATA.
  - No pulse is emitted for an aborted frame.
- PRESCALE handling:
  - Registered into P on the IDLE to START transition; changes mid-frame have no effect.
  - Any value other than 16 or 32 is treated as 8.
  - H = P/2.
- edge_cnt runs 0..P-1 in every non-IDLE state, wraps to 0 at P-1, and is cleared on each state entry.
- Sampler:
  - RX_IN is captured at edge_cnt = H-1, H and H+1.
  - sampled_bit is registered from the majority of the three captures at the end of the H+1 cycle, so it is valid from edge_cnt = H+2.
- IDLE: RX_IN = 0 moves to START with edge_cnt = 0 on the next cycle.
- START: at edge_cnt = P-1:
  - sampled_bit = 1: pulse strt_err, return to IDLE.
  - otherwise: go to DATA with bit_cnt = 0.
- DATA:
  - At edge_cnt = H+2, write sampled_bit into P_DATA[bit_cnt].
  - At edge_cnt = P-1, increment bit_cnt.
  - After bit DATA_LENGTH-1: go to PARITY if PAR_EN = 1, else STOP.
  - PAR_EN is registered at frame start.
- PARITY:
  - par_chk_en is high for exactly one cycle, at edge_cnt = H+2.
  - At edge_cnt = H+3, par_err is latched into an internal sticky flag.
  - At edge_cnt = P-1, go to STOP.
  - par_err is ignored in every other cycle and state.
- STOP: at edge_cnt = H+2, evaluate and return to IDLE. This early return resynchronizes for back-to-back frames.
  - sampled_bit = 0: pulse stp_err.
  - parity flag set: pulse par_fail (can coincide with stp_err).
  - Neither error: pulse data_valid.
  - Clear the parity flag.
- P_DATA:
  - Holds its value from frame end until the first data write of the next frame.
  - It is stable throughout PARITY, so the checker sees the final word.
- A start edge arriving in the IDLE cycle right after STOP is accepted; no frame is lost.
- par_chk_en never asserts when PAR_EN = 0.

Test Plan:
- PRESCALE = 8, PAR_EN = 0, frame 0xA5 with stop = 1 -> P_DATA = 0xA5; data_valid pulses once, at STOP edge_cnt = 6; no error pulses; busy low afterwards.
- PRESCALE = 16, PAR_EN = 1, 0x3C with correct even parity (par_err held 0) -> par_chk_en is a single pulse at PARITY edge_cnt = 10; data_valid = 1; par_fail = 0.
- Same frame with par_err driven 1 at the latch cycle -> par_fail pulses, data_valid stays 0; the following clean frame gives data_valid = 1 (flag cleared).
- RX_IN low for 3 clocks then high, PRESCALE = 8 -> strt_err pulses at START edge_cnt = 7; returns to IDLE; no DATA entry.
- 0x55 with stop bit 0, PRESCALE = 32 -> stp_err pulses, data_valid = 0, P_DATA = 0x55. Next: back-to-back frames 0x01, 0xFF with no idle gap -> two data_valid pulses, correct values.
- RST_fsm asserted mid-DATA (bit 4), PRESCALE = 16 -> outputs go to 0 asynchronously; no pulses; after release, the next frame 0x81 is received correctly.
